// File: rtl/spi_pkg.sv
// Shared types and constants for the multi-chip-select SPI master.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    XFER  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // SPI mode encodings as {cpol, cpha}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  localparam int unsigned DEF_DIV_W = 16;

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK half-period timer: one-cycle tick every div cycles while enabled.
module spi_clk_gen #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick_c
);

  logic [DIV_W-1:0] cnt;

  // Down-counter; reloads while disabled and on every tick so the first tick lands div cycles after enable
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      cnt <= '0;
    end else if (!en || (cnt == '0)) begin
      cnt <= div - DIV_W'(1);
    end else begin
      cnt <= cnt - DIV_W'(1);
    end
  end

  assign tick_c = en && (cnt == '0);

endmodule

// File: rtl/spi_master_mc.sv
// SPI master with run-time mode, bit order, SCLK divider and N slave selects.
module spi_master_mc
  import spi_pkg::*;
#(
  parameter int unsigned SPI_MAXLEN = 32,
  parameter int unsigned NUM_CS     = 4,
  parameter int unsigned DIV_W      = DEF_DIV_W,
  localparam int unsigned CS_W      = (NUM_CS > 1) ? $clog2(NUM_CS) : 1,
  localparam int unsigned NW        = $clog2(SPI_MAXLEN) + 1
) (
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic                  start_cmd,
  output logic                  spi_drv_rdy,
  output logic                  done,
  input  logic [NW-1:0]         n_clks,
  input  logic [SPI_MAXLEN-1:0] tx_data,
  output logic [SPI_MAXLEN-1:0] rx_miso,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic                  lsb_first,
  input  logic [CS_W-1:0]       cs_sel,
  input  logic [DIV_W-1:0]      half_div,
  output logic                  SCLK,
  output logic                  MOSI,
  input  logic                  MISO,
  output logic [NUM_CS-1:0]     SS_N
);

  localparam int unsigned M  = SPI_MAXLEN;
  localparam int unsigned EW = $clog2(2 * SPI_MAXLEN) + 1;
  localparam logic [NW-1:0] MAXN = NW'(SPI_MAXLEN);

  state_t state, state_nx;

  logic [NW-1:0]    n_q;
  logic [DIV_W-1:0] hd_q;
  logic             cpol_q, cpha_q, lsb_q;
  logic [M-1:0]     tx_sr, rx_sr, tx_sr_d, rx_sr_d, rx_miso_d;
  logic [EW-1:0]    edge_q, edge_d, edge_k_c;
  logic             sclk_d, mosi_d, done_d, rdy_d;
  logic [NUM_CS-1:0] ss_n_d;

  logic [NW-1:0]    n_eff_c;
  logic [DIV_W-1:0] hd_eff_c, div_c;
  logic [M-1:0]     aligned_c;
  logic             accept_c, tick_c, edge_c, last_c, lead_c;
  logic             shift_lead_c, sample_c, drive_c;
  logic [1:0]       mode_c;

  function automatic logic head(input logic [M-1:0] sr, input logic lsb);
    return lsb ? sr[0] : sr[M-1];
  endfunction

  function automatic logic [M-1:0] advance(input logic [M-1:0] sr, input logic lsb);
    return lsb ? (sr >> 1) : (sr << 1);
  endfunction

  // Command qualification and argument normalisation
  assign n_eff_c   = (n_clks > MAXN) ? MAXN : n_clks;
  assign hd_eff_c  = (half_div == '0) ? DIV_W'(1) : half_div;
  assign accept_c  = start_cmd && spi_drv_rdy && (n_clks != '0) && (32'(cs_sel) < NUM_CS);
  assign aligned_c = lsb_first ? tx_data : (tx_data << (MAXN - n_eff_c));

  // Edge bookkeeping: edge_k_c is the index of the SCLK edge a tick would produce
  assign div_c        = (state == IDLE) ? hd_eff_c : hd_q;
  assign edge_c       = tick_c && ((state == SETUP) || (state == XFER));
  assign edge_k_c     = edge_q + EW'(1);
  assign last_c       = (edge_k_c == EW'({n_q, 1'b0}));
  assign lead_c       = edge_k_c[0];
  assign mode_c       = {cpol_q, cpha_q};
  assign shift_lead_c = (mode_c == MODE1) || (mode_c == MODE3);
  assign sample_c     = edge_c && (lead_c != shift_lead_c);
  assign drive_c      = edge_c && (shift_lead_c ? lead_c : (!lead_c && !last_c));

  spi_clk_gen #(.DIV_W(DIV_W)) u_clk_gen (
    .clk     (clk),
    .aresetn (aresetn),
    .en      (state != IDLE),
    .div     (div_c),
    .tick_c  (tick_c)
  );

  // State register
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept_c)          state_nx = SETUP;
      SETUP:   if (tick_c)            state_nx = XFER;
      XFER:    if (tick_c && last_c)  state_nx = HOLD;
      HOLD:    if (tick_c)            state_nx = IDLE;
      default:                        state_nx = IDLE;
    endcase
  end

  // Next values for the registered outputs and shift registers
  always_comb begin
    tx_sr_d   = tx_sr;
    rx_sr_d   = rx_sr;
    edge_d    = edge_q;
    sclk_d    = SCLK;
    mosi_d    = MOSI;
    ss_n_d    = SS_N;
    done_d    = 1'b0;
    rdy_d     = spi_drv_rdy;
    rx_miso_d = rx_miso;
    case (state)
      IDLE: begin
        sclk_d = cpol;
        mosi_d = 1'b0;
        if (accept_c) begin
          ss_n_d  = ~(NUM_CS'(1) << cs_sel);
          rdy_d   = 1'b0;
          edge_d  = '0;
          rx_sr_d = '0;
          if (cpha) begin
            tx_sr_d = aligned_c;
          end else begin
            mosi_d  = head(aligned_c, lsb_first);
            tx_sr_d = advance(aligned_c, lsb_first);
          end
        end
      end
      SETUP, XFER: begin
        if (edge_c) begin
          sclk_d = ~SCLK;
          edge_d = edge_k_c;
        end
        if (sample_c) begin
          rx_sr_d = lsb_q ? {MISO, rx_sr[M-1:1]} : {rx_sr[M-2:0], MISO};
        end
        if (drive_c) begin
          mosi_d  = head(tx_sr, lsb_q);
          tx_sr_d = advance(tx_sr, lsb_q);
        end
      end
      HOLD: begin
        if (tick_c) begin
          ss_n_d    = '1;
          done_d    = 1'b1;
          rdy_d     = 1'b1;
          mosi_d    = 1'b0;
          rx_miso_d = lsb_q ? (rx_sr >> (MAXN - n_q)) : rx_sr;
        end
      end
      default: ;
    endcase
  end

  // Latch the command arguments at accept
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      n_q    <= '0;
      hd_q   <= DIV_W'(1);
      cpol_q <= 1'b0;
      cpha_q <= 1'b0;
      lsb_q  <= 1'b0;
    end else if (accept_c) begin
      n_q    <= n_eff_c;
      hd_q   <= hd_eff_c;
      cpol_q <= cpol;
      cpha_q <= cpha;
      lsb_q  <= lsb_first;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      tx_sr       <= '0;
      rx_sr       <= '0;
      edge_q      <= '0;
      SCLK        <= 1'b0;
      MOSI        <= 1'b0;
      SS_N        <= '1;
      done        <= 1'b0;
      spi_drv_rdy <= 1'b1;
      rx_miso     <= '0;
    end else begin
      tx_sr       <= tx_sr_d;
      rx_sr       <= rx_sr_d;
      edge_q      <= edge_d;
      SCLK        <= sclk_d;
      MOSI        <= mosi_d;
      SS_N        <= ss_n_d;
      done        <= done_d;
      spi_drv_rdy <= rdy_d;
      rx_miso     <= rx_miso_d;
    end
  end

endmodule

// File: tb/tb_spi_master_mc.sv
// Directed self-checking bench for spi_master_mc with MOSI looped back to MISO.
module tb_spi_master_mc;

  // Five selects so that cs_sel=5 is representable and out of range
  localparam int unsigned M   = 32;
  localparam int unsigned NCS = 5;
  localparam int unsigned DW  = 16;
  localparam int unsigned CSW = 3;
  localparam int unsigned NW  = 6;

  logic           clk = 1'b0;
  logic           aresetn = 1'b0;
  logic           start_cmd = 1'b0;
  logic           cpol = 1'b0, cpha = 1'b0, lsb_first = 1'b0;
  logic [NW-1:0]  n_clks = '0;
  logic [M-1:0]   tx_data = '0;
  logic [CSW-1:0] cs_sel = '0;
  logic [DW-1:0]  half_div = '0;
  logic           spi_drv_rdy, done, SCLK, MOSI, MISO;
  logic [M-1:0]   rx_miso;
  logic [NCS-1:0] SS_N;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;
  assign MISO = MOSI;

  spi_master_mc #(.SPI_MAXLEN(M), .NUM_CS(NCS), .DIV_W(DW)) dut (
    .clk         (clk),
    .aresetn     (aresetn),
    .start_cmd   (start_cmd),
    .spi_drv_rdy (spi_drv_rdy),
    .done        (done),
    .n_clks      (n_clks),
    .tx_data     (tx_data),
    .rx_miso     (rx_miso),
    .cpol        (cpol),
    .cpha        (cpha),
    .lsb_first   (lsb_first),
    .cs_sel      (cs_sel),
    .half_div    (half_div),
    .SCLK        (SCLK),
    .MOSI        (MOSI),
    .MISO        (MISO),
    .SS_N        (SS_N)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one command and follow it to done, checking timing, selects and data
  task automatic run_xfer(input string tag, input int n, input logic [M-1:0] tx,
                          input logic pol, input logic pha, input logic lsb,
                          input int cs, input int hd, input logic [M-1:0] exp_rx,
                          input logic exp_first);
    int hd_e, n_e, edges, last, done_c;
    logic prev, first, gap_ok, ss_ok;
    logic [NCS-1:0] ss_exp;
    hd_e   = (hd == 0) ? 1 : hd;
    n_e    = (n > int'(M)) ? int'(M) : n;
    ss_exp = ~(NCS'(1) << cs);
    @(negedge clk);
    n_clks = NW'(n); tx_data = tx; cpol = pol; cpha = pha; lsb_first = lsb;
    cs_sel = CSW'(cs); half_div = DW'(hd); start_cmd = 1'b1;
    @(negedge clk);
    start_cmd = 1'b0;
    chk({tag, "_idle_sclk"}, 64'(SCLK), 64'(pol));
    chk({tag, "_rdy_low"}, 64'(spi_drv_rdy), 64'(0));
    prev = SCLK; edges = 0; last = 0; done_c = -1; gap_ok = 1'b1; ss_ok = 1'b1;
    first = pha ? 1'b0 : MOSI;
    for (int c = 0; c < 400; c++) begin
      if (c > 0) @(negedge clk);
      if (done === 1'b1) begin
        done_c = c;
        break;
      end
      if (SS_N !== ss_exp) ss_ok = 1'b0;
      if (SCLK !== prev) begin
        edges++;
        if (c - last != hd_e) gap_ok = 1'b0;
        last = c;
        if (edges == 1 && pha) first = MOSI;
        prev = SCLK;
      end
    end
    chk({tag, "_done_cycle"}, 64'(done_c), 64'((2 * n_e + 1) * hd_e));
    chk({tag, "_edges"}, 64'(edges), 64'(2 * n_e));
    chk({tag, "_edge_gap"}, 64'(gap_ok), 64'(1));
    chk({tag, "_ss_during"}, 64'(ss_ok), 64'(1));
    chk({tag, "_first_mosi"}, 64'(first), 64'(exp_first));
    chk({tag, "_rx"}, 64'(rx_miso), 64'(exp_rx));
    chk({tag, "_ss_release"}, 64'(SS_N), 64'({NCS{1'b1}}));
    chk({tag, "_rdy_at_done"}, 64'(spi_drv_rdy), 64'(1));
    @(negedge clk);
    chk({tag, "_done_1cyc"}, 64'(done), 64'(0));
    chk({tag, "_sclk_rest"}, 64'(SCLK), 64'(pol));
  endtask

  // Offer a command that must be dropped and confirm nothing starts
  task automatic ignored(input string tag, input int n, input int cs);
    logic ok_rdy, ok_quiet;
    @(negedge clk);
    n_clks = NW'(n); cs_sel = CSW'(cs); half_div = DW'(2); start_cmd = 1'b1;
    @(negedge clk);
    start_cmd = 1'b0;
    ok_rdy = 1'b1; ok_quiet = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (spi_drv_rdy !== 1'b1) ok_rdy = 1'b0;
      if (done !== 1'b0 || SS_N !== {NCS{1'b1}}) ok_quiet = 1'b0;
      @(negedge clk);
    end
    chk({tag, "_rdy_stays"}, 64'(ok_rdy), 64'(1));
    chk({tag, "_quiet"}, 64'(ok_quiet), 64'(1));
  endtask

  initial begin
    int d1, d2, pulses;
    logic ok;
    logic [M-1:0] rx1, rx2;
    logic [NCS-1:0] ss1, ss_after;

    repeat (3) @(negedge clk);
    chk("reset_rdy", 64'(spi_drv_rdy), 64'(1));
    chk("reset_done", 64'(done), 64'(0));
    chk("reset_rx", 64'(rx_miso), 64'(0));
    chk("reset_pins", 64'({SCLK, MOSI, SS_N}), 64'({1'b0, 1'b0, 5'h1f}));
    aresetn = 1'b1;

    run_xfer("m0_msb", 8, 32'hA5, 1'b0, 1'b0, 1'b0, 0, 2, 32'hA5, 1'b1);
    run_xfer("m3_lsb", 12, 32'h0F3C, 1'b1, 1'b1, 1'b1, 2, 3, 32'h0F3C, 1'b0);
    ignored("n0", 0, 0);
    ignored("cs5", 8, 5);
    run_xfer("hd0", 1, 32'h1, 1'b0, 1'b1, 1'b0, 4, 0, 32'h1, 1'b1);
    run_xfer("clamp", 40, 32'hDEADBEEF, 1'b0, 0, 0, 1, 1, 32'hDEADBEEF, 1'b1);
    run_xfer("upper0", 4, 32'hFFFFFFF6, 1'b0, 1'b0, 1'b0, 3, 1, 32'h6, 1'b0);

    // Reset in the middle of a 32-bit mode 2 transfer
    @(negedge clk);
    n_clks = NW'(32); tx_data = 32'h12345678; cpol = 1'b1; cpha = 1'b0;
    lsb_first = 1'b0; cs_sel = CSW'(1); half_div = DW'(2); start_cmd = 1'b1;
    @(negedge clk);
    start_cmd = 1'b0;
    repeat (20) @(negedge clk);
    chk("rst_pre_ss", 64'(SS_N), 64'(5'b11101));
    chk("rst_pre_sclk", 64'(SCLK), 64'(1));
    #2 aresetn = 1'b0;
    #1;
    chk("rst_async_pins", 64'({SCLK, MOSI, SS_N, spi_drv_rdy, done}),
        64'({1'b0, 1'b0, 5'h1f, 1'b1, 1'b0}));
    chk("rst_async_rx", 64'(rx_miso), 64'(0));
    @(negedge clk);
    aresetn = 1'b1;
    ok = 1'b1;
    for (int c = 0; c < 150; c++) begin
      @(negedge clk);
      if (done !== 1'b0 || spi_drv_rdy !== 1'b1) ok = 1'b0;
    end
    chk("rst_no_done", 64'(ok), 64'(1));
    run_xfer("post_rst", 16, 32'hBEEF, 1'b0, 1'b0, 1'b0, 3, 1, 32'hBEEF, 1'b1);

    // Back-to-back with start_cmd held high and tx_data changing mid-transfer
    @(negedge clk);
    n_clks = NW'(8); tx_data = 32'h3C; cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0;
    cs_sel = CSW'(0); half_div = DW'(1); start_cmd = 1'b1;
    d1 = -1; d2 = -1; pulses = 0; rx1 = '0; rx2 = '0; ss1 = '0; ss_after = '1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (c == 5)  tx_data = 32'hC3;
      if (c == 25) tx_data = 32'hFF;
      if (done === 1'b1) begin
        pulses++;
        if (d1 < 0) begin
          d1 = c; rx1 = rx_miso; ss1 = SS_N;
        end else if (d2 < 0) begin
          d2 = c; rx2 = rx_miso;
        end
      end
      if (d1 >= 0 && c == d1 + 1) begin
        ss_after = SS_N;
        start_cmd = 1'b0;
      end
    end
    start_cmd = 1'b0;
    chk("b2b_done1", 64'(d1), 64'(17));
    chk("b2b_rx1", 64'(rx1), 64'(32'h3C));
    chk("b2b_ss_high", 64'(ss1), 64'(5'h1f));
    chk("b2b_ss_refall", 64'(ss_after), 64'(5'h1e));
    chk("b2b_done2", 64'(d2), 64'(35));
    chk("b2b_rx2", 64'(rx2), 64'(32'hC3));
    chk("b2b_pulses", 64'(pulses), 64'(2));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
